// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and M-stage accesses
//
// Purpose: sequences at most one data access, then one instruction fetch, per
// pipeline step, and holds the pipeline (stall) until both have completed.
// Data goes first so the older instruction completes first and fetch is never starved.
//
// Ports:
//   clk, reset             clock, synchronous active-low reset
//   i_req, pcF, instrF     fetch request, fetch address, fetched instruction
//   d_req, memwriteM,      M-stage access request, store/load select,
//   aluoutM, writedataM,   data address, store data,
//   readdataM              load data
//   stall                  hold all pipeline registers this cycle
//   mem_req/we/addr/wdata  memory request, held until mem_ready
//   mem_ready, mem_rdata   one-cycle completion pulse and read data
//
// Build option: MEMARB_IBUF_EN adds a one-entry fetch buffer that lets a repeated
// fetch of the same word skip the memory access.

module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] pcF,
  output logic [DW-1:0] instrF,
  input  logic          d_req,
  input  logic          memwriteM,
  input  logic [AW-1:0] aluoutM,
  input  logic [DW-1:0] writedataM,
  output logic [DW-1:0] readdataM,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DBUSY = 2'd1,
    IBUSY = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          stall_c;
  logic          req_c;
  logic          we_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wdata_c;

  // fetch_hit: the buffered word serves this step's fetch without a memory access
  logic          fetch_hit;
  logic [DW-1:0] hit_instr;

`ifdef MEMARB_IBUF_EN
  logic          ibuf_valid_q, ibuf_valid_d;
  logic [AW-3:0] ibuf_addr_q, ibuf_addr_d;
  logic [DW-1:0] ibuf_data_q, ibuf_data_d;
  logic          store_kill;

  // A store in this step that overwrites the buffered word invalidates it, and
  // the fetch of that same step must already see the entry as gone.
  assign store_kill = d_req && memwriteM && (aluoutM[AW-1:2] == ibuf_addr_q);
  assign fetch_hit  = ibuf_valid_q && (ibuf_addr_q == pcF[AW-1:2]) && !store_kill;
  assign hit_instr  = ibuf_data_q;
`else
  assign fetch_hit  = 1'b0;
  assign hit_instr  = '0;
`endif

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rdata_d = rdata_q;
`ifdef MEMARB_IBUF_EN
    ibuf_valid_d = ibuf_valid_q;
    ibuf_addr_d  = ibuf_addr_q;
    ibuf_data_d  = ibuf_data_q;
`endif
    stall_c = 1'b0;
    req_c   = 1'b0;
    we_c    = 1'b0;
    addr_c  = '0;
    wdata_c = '0;

    case (state_q)
      IDLE: begin
        stall_c = d_req | i_req;
        if (d_req) begin
          state_d = DBUSY;
        end else if (i_req) begin
          if (fetch_hit) begin
            state_d = DONE;
            instr_d = hit_instr;
          end else begin
            state_d = IBUSY;
          end
        end
      end

      DBUSY: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        we_c    = memwriteM;
        addr_c  = aluoutM;
        wdata_c = writedataM;
        if (mem_ready) begin
          if (!memwriteM) begin
            rdata_d = mem_rdata;
          end
`ifdef MEMARB_IBUF_EN
          if (store_kill) begin
            ibuf_valid_d = 1'b0;
          end
`endif
          if (i_req && fetch_hit) begin
            state_d = DONE;
            instr_d = hit_instr;
          end else if (i_req) begin
            state_d = IBUSY;
          end else begin
            state_d = DONE;
          end
        end
      end

      IBUSY: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        addr_c  = pcF;
        if (mem_ready) begin
          instr_d = mem_rdata;
          state_d = DONE;
`ifdef MEMARB_IBUF_EN
          ibuf_valid_d = 1'b1;
          ibuf_addr_d  = pcF[AW-1:2];
          ibuf_data_d  = mem_rdata;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // While reset is held the port is quiet and the pipeline is not held,
    // so an abandoned access drops its request immediately.
    if (!reset) begin
      stall_c = 1'b0;
      req_c   = 1'b0;
      we_c    = 1'b0;
      addr_c  = '0;
      wdata_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      rdata_q <= '0;
`ifdef MEMARB_IBUF_EN
      ibuf_valid_q <= 1'b0;
      ibuf_addr_q  <= '0;
      ibuf_data_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
`ifdef MEMARB_IBUF_EN
      ibuf_valid_q <= ibuf_valid_d;
      ibuf_addr_q  <= ibuf_addr_d;
      ibuf_data_q  <= ibuf_data_d;
`endif
    end
  end

  assign stall     = stall_c;
  assign mem_req   = req_c;
  assign mem_we    = we_c;
  assign mem_addr  = addr_c;
  assign mem_wdata = wdata_c;
  assign instrF    = instr_q;
  assign readdataM = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        d_req;
  logic        memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .pcF        (pcF),
    .instrF     (instrF),
    .d_req      (d_req),
    .memwriteM  (memwriteM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } txn_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rd;
    int          cycles;
  } step_t;

  txn_t  txn_q[$];
  step_t step_q[$];

  int n_checks = 0;
  int n_errors = 0;
  bit manual   = 1'b0;
  int wcnt     = 0;

  logic [31:0] exp_instr = '0;
  logic [31:0] exp_rd    = '0;
  logic        bv = 1'b0;
  logic [29:0] ba = '0;
  logic [31:0] bd = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Memory model: answers each request after its scripted wait count and
  // checks the request against the oldest expected transaction.
  always @(negedge clk) begin
    if (!manual) begin
      if (mem_req) begin
        if (txn_q.size() == 0) begin
          check_eq("unexpected_mem_req", 64'(mem_addr), 64'hffff_ffff_ffff_ffff);
          mem_ready = 1'b0;
        end else begin
          check_eq("mem_we", 64'(mem_we), 64'(txn_q[0].we));
          check_eq("mem_addr", 64'(mem_addr), 64'(txn_q[0].addr));
          if (txn_q[0].we) check_eq("mem_wdata", 64'(mem_wdata), 64'(txn_q[0].wdata));
          if (wcnt == txn_q[0].waits) begin
            mem_ready = 1'b1;
            mem_rdata = txn_q[0].rdata;
            void'(txn_q.pop_front());
            wcnt = 0;
          end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            wcnt++;
          end
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic run_step(input string name,
                          input logic d, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdv, input int dw,
                          input logic i, input logic [31:0] pc, input logic [31:0] ird,
                          input int iw);
    txn_t  t;
    step_t s;
    int    cyc;
    int    n;
    logic  hit;
    @(posedge clk);
    #1;
    d_req = d; memwriteM = we; aluoutM = a; writedataM = wd;
    i_req = i; pcF = pc;
    cyc = (d || i) ? 2 : 1;
    if (d) begin
      t.we = we; t.addr = a; t.wdata = wd; t.rdata = rdv; t.waits = dw;
      txn_q.push_back(t);
      cyc += 1 + dw;
      if (!we) exp_rd = rdv;
`ifdef MEMARB_IBUF_EN
      if (we && bv && a[31:2] == ba) bv = 1'b0;
`endif
    end
    if (i) begin
`ifdef MEMARB_IBUF_EN
      hit = bv && (ba == pc[31:2]);
`else
      hit = 1'b0;
`endif
      if (hit) begin
        exp_instr = bd;
      end else begin
        t.we = 1'b0; t.addr = pc; t.wdata = '0; t.rdata = ird; t.waits = iw;
        txn_q.push_back(t);
        cyc += 1 + iw;
        exp_instr = ird;
        bv = 1'b1; ba = pc[31:2]; bd = ird;
      end
    end
    s.instr = exp_instr; s.rd = exp_rd; s.cycles = cyc;
    step_q.push_back(s);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 60);
    if (stall) check_eq({name, "_timeout"}, 64'(n), 64'(cyc));
    s = step_q.pop_front();
    check_eq({name, "_cycles"}, 64'(n), 64'(s.cycles));
    check_eq({name, "_instrF"}, 64'(instrF), 64'(s.instr));
    check_eq({name, "_readdataM"}, 64'(readdataM), 64'(s.rd));
    check_eq({name, "_done_mem_req"}, 64'(mem_req), 64'd0);
    check_eq({name, "_txn_left"}, 64'(txn_q.size()), 64'd0);
    txn_q.delete();
  endtask

  initial begin
    reset = 1'b0; manual = 1'b0;
    i_req = 1'b1; d_req = 1'b1; memwriteM = 1'b1;
    pcF = 32'h40; aluoutM = 32'h80; writedataM = 32'h1234;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_mem_req", 64'(mem_req), 64'd0);
    check_eq("rst_mem_we", 64'(mem_we), 64'd0);
    check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check_eq("rst_instrF", 64'(instrF), 64'd0);
    check_eq("rst_readdataM", 64'(readdataM), 64'd0);
    @(posedge clk);
    #1;
    i_req = 1'b0; d_req = 1'b0; memwriteM = 1'b0;
    reset = 1'b1;

    run_step("fetch0", 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h2008_0005, 0);
    run_step("load_fetch", 1, 0, 32'h44, 0, 32'hDEAD_BEEF, 2, 1, 32'h8, 32'h0000_1111, 0);
    run_step("store_fetch", 1, 1, 32'h50, 32'h7, 0, 2, 1, 32'hC, 32'h0000_2222, 0);
    run_step("idle", 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    run_step("load_only", 1, 0, 32'h60, 0, 32'hCAFE_F00D, 1, 0, 32'h0, 0, 0);
    run_step("fetch_wait3", 0, 0, 0, 0, 0, 0, 1, 32'h14, 32'h0000_3333, 3);
    run_step("fetch10_a", 0, 0, 0, 0, 0, 0, 1, 32'h10, 32'h1010_1010, 0);
    run_step("fetch10_b", 0, 0, 0, 0, 0, 0, 1, 32'h10, 32'h1010_1010, 0);
    run_step("store10", 1, 1, 32'h10, 32'h55, 0, 0, 1, 32'h18, 32'h0000_4444, 0);
    run_step("fetch10_c", 0, 0, 0, 0, 0, 0, 1, 32'h10, 32'h1010_2020, 1);
    run_step("fetch10_d", 0, 0, 0, 0, 0, 0, 1, 32'h10, 32'h1010_2020, 0);
    run_step("store_same", 1, 1, 32'h10, 32'h66, 0, 0, 1, 32'h10, 32'h1010_3030, 0);

    // Reset while the fetch is outstanding
    @(posedge clk);
    #1;
    manual = 1'b1;
    d_req = 1'b0; i_req = 1'b1; pcF = 32'h30;
    @(negedge clk);
    check_eq("rstmid_idle_stall", 64'(stall), 64'd1);
    @(negedge clk);
    check_eq("rstmid_ibusy_req", 64'(mem_req), 64'd1);
    check_eq("rstmid_ibusy_addr", 64'(mem_addr), 64'h30);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rstmid_req", 64'(mem_req), 64'd0);
    check_eq("rstmid_stall", 64'(stall), 64'd0);
    check_eq("rstmid_instrF", 64'(instrF), 64'd0);
    check_eq("rstmid_readdataM", 64'(readdataM), 64'd0);
    reset = 1'b1; i_req = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check_eq("late_ready_req", 64'(mem_req), 64'd0);
    check_eq("late_ready_stall", 64'(stall), 64'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq("late_ready_instrF", 64'(instrF), 64'd0);
    exp_instr = '0; exp_rd = '0; bv = 1'b0;
    manual = 1'b0;

    run_step("after_rst", 0, 0, 0, 0, 0, 0, 1, 32'h30, 32'h3030_3030, 0);

    for (int k = 0; k < 12; k++) begin
      run_step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 7)) << 2, $urandom, $urandom, $urandom_range(0, 2),
               1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 2,
               $urandom, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d exp %0d", n_checks, 0);
    $fatal(1, "timeout");
  end

endmodule
